// File: rtl/display_capture.sv
// display_capture: receive side of the display sequencer. Rebuilds the
// twelve-word result frame (PE, 3x3, 2x2 groups; c11, c12, c21, c22 each)
// into a shadow bank and commits it atomically to the output registers.
// Optional feature: define DISPLAY_CAPTURE_SUM_EN to add sum_o, the sum
// of all words of the last committed frame.
module display_capture #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        tag_i,
  output logic [DATA_W-1:0] c11_PE_o,
  output logic [DATA_W-1:0] c12_PE_o,
  output logic [DATA_W-1:0] c21_PE_o,
  output logic [DATA_W-1:0] c22_PE_o,
  output logic [DATA_W-1:0] c11_3x3_o,
  output logic [DATA_W-1:0] c12_3x3_o,
  output logic [DATA_W-1:0] c21_3x3_o,
  output logic [DATA_W-1:0] c22_3x3_o,
  output logic [DATA_W-1:0] c11_2x2_o,
  output logic [DATA_W-1:0] c12_2x2_o,
  output logic [DATA_W-1:0] c21_2x2_o,
  output logic [DATA_W-1:0] c22_2x2_o,
  output logic              frame_done_o,
  output logic              frame_err_o,
`ifdef DISPLAY_CAPTURE_SUM_EN
  output logic [DATA_W+3:0] sum_o,
`endif
  output logic [2:0]        cap_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PE     = 3'd1,
    S_3X3    = 3'd2,
    S_2X2    = 3'd3,
    S_COMMIT = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [1:0]        idx_q;
  logic [7:0]        tcnt_q;
  logic              err_q;
  logic [DATA_W-1:0] shadow_q [12];
  logic [DATA_W-1:0] bank_q   [12];

  logic              accept, first_word, last_word, in_frame;
  logic [1:0]        grp;
  logic [2:0]        exp_tag;
  logic [3:0]        slot;

`ifdef DISPLAY_CAPTURE_SUM_EN
  logic [DATA_W+3:0] acc_q;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode: word acceptance, group sequencing, timeout and error entry
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    first_word = 1'b0;
    last_word  = 1'b0;
    in_frame   = 1'b0;
    grp        = 2'd0;
    exp_tag    = 3'd1;
    case (state_q)
      S_IDLE, S_COMMIT: begin
        state_d = S_IDLE;
        if (valid_i) begin
          if (tag_i == 3'd1) begin
            accept     = 1'b1;
            first_word = 1'b1;
            state_d    = S_PE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_PE, S_3X3, S_2X2: begin
        in_frame = 1'b1;
        grp      = (state_q == S_PE) ? 2'd0 : (state_q == S_3X3) ? 2'd1 : 2'd2;
        exp_tag  = {1'b0, grp} + 3'd1;
        if (valid_i) begin
          if (tag_i == exp_tag) begin
            accept = 1'b1;
            if (idx_q == 2'd3) begin
              case (state_q)
                S_PE:    state_d = S_3X3;
                S_3X3:   state_d = S_2X2;
                default: begin
                  last_word = 1'b1;
                  state_d   = S_COMMIT;
                end
              endcase
            end
          end else begin
            state_d = S_ERR;
          end
        end else if (tcnt_q >= TIMEOUT_M1) begin
          state_d = S_ERR;
        end
      end
      S_ERR:   state_d = valid_i ? S_ERR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    slot = first_word ? 4'd0 : {grp, idx_q};
  end

  // Shadow capture, idle-gap counter, sticky error and commit into the output bank.
  // The commit copy happens on the edge that accepts the 12th word (that word goes
  // straight to the bank), so the bank is already valid during the S_COMMIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      tcnt_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < 12; i++) begin
        shadow_q[i] <= '0;
        bank_q[i]   <= '0;
      end
`ifdef DISPLAY_CAPTURE_SUM_EN
      acc_q <= '0;
      sum_o <= '0;
`endif
    end else if (state_d == S_ERR) begin
      err_q  <= 1'b1;
      idx_q  <= '0;
      tcnt_q <= '0;
`ifdef DISPLAY_CAPTURE_SUM_EN
      acc_q  <= '0;
`endif
    end else if (accept) begin
      shadow_q[slot] <= data_i;
      idx_q          <= first_word ? 2'd1 : idx_q + 2'd1;
      tcnt_q         <= '0;
`ifdef DISPLAY_CAPTURE_SUM_EN
      acc_q <= first_word ? {4'b0, data_i} : acc_q + {4'b0, data_i};
`endif
      if (last_word) begin
        for (int unsigned i = 0; i < 11; i++) bank_q[i] <= shadow_q[i];
        bank_q[11] <= data_i;
`ifdef DISPLAY_CAPTURE_SUM_EN
        sum_o <= acc_q + {4'b0, data_i};
`endif
      end
    end else if (in_frame) begin
      tcnt_q <= tcnt_q + 8'd1;
    end
  end

  assign c11_PE_o     = bank_q[0];
  assign c12_PE_o     = bank_q[1];
  assign c21_PE_o     = bank_q[2];
  assign c22_PE_o     = bank_q[3];
  assign c11_3x3_o    = bank_q[4];
  assign c12_3x3_o    = bank_q[5];
  assign c21_3x3_o    = bank_q[6];
  assign c22_3x3_o    = bank_q[7];
  assign c11_2x2_o    = bank_q[8];
  assign c12_2x2_o    = bank_q[9];
  assign c21_2x2_o    = bank_q[10];
  assign c22_2x2_o    = bank_q[11];
  assign frame_done_o = (state_q == S_COMMIT);
  assign frame_err_o  = err_q;
  assign cap_state_o  = state_q;

endmodule

// File: tb/tb_display_capture.sv
// Self-checking bench for display_capture: directed frames plus randomized
// frames compared cycle by cycle against a word-count based reference model.
module tb_display_capture;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic [2:0]    tag_i;
  logic [DW-1:0] c_o [12];
  logic          frame_done_o, frame_err_o;
  logic [2:0]    cap_state_o;
`ifdef DISPLAY_CAPTURE_SUM_EN
  logic [DW+3:0] sum_o;
`endif

  display_capture #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i), .tag_i(tag_i),
    .c11_PE_o(c_o[0]), .c12_PE_o(c_o[1]), .c21_PE_o(c_o[2]), .c22_PE_o(c_o[3]),
    .c11_3x3_o(c_o[4]), .c12_3x3_o(c_o[5]), .c21_3x3_o(c_o[6]), .c22_3x3_o(c_o[7]),
    .c11_2x2_o(c_o[8]), .c12_2x2_o(c_o[9]), .c21_2x2_o(c_o[10]), .c22_2x2_o(c_o[11]),
    .frame_done_o(frame_done_o), .frame_err_o(frame_err_o),
`ifdef DISPLAY_CAPTURE_SUM_EN
    .sum_o(sum_o),
`endif
    .cap_state_o(cap_state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: m_pos = words accepted in the current frame (0 = waiting for a frame)
  int            m_pos, m_gap;
  bit            m_in_err, m_sticky, m_committed;
  logic [DW-1:0] m_buf [12];
  logic [DW-1:0] m_out [12];
  int            m_sum;

  task automatic model_reset();
    m_pos = 0; m_gap = 0; m_in_err = 0; m_sticky = 0; m_committed = 0; m_sum = 0;
    for (int i = 0; i < 12; i++) begin
      m_buf[i] = '0;
      m_out[i] = '0;
    end
  endtask

  task automatic model_err();
    m_in_err = 1; m_sticky = 1; m_pos = 0; m_gap = 0;
  endtask

  task automatic model_step(input bit v, input logic [2:0] t, input logic [DW-1:0] d);
    m_committed = 0;
    if (m_in_err) begin
      if (!v) m_in_err = 0;
    end else if (m_pos == 0) begin
      if (v) begin
        if (t == 3'd1) begin
          m_buf[0] = d; m_pos = 1; m_gap = 0;
        end else model_err();
      end
    end else if (v) begin
      if (int'(t) == m_pos / 4 + 1) begin
        m_buf[m_pos] = d; m_pos++; m_gap = 0;
        if (m_pos == 12) begin
          m_out = m_buf;
          m_sum = 0;
          for (int i = 0; i < 12; i++) m_sum += int'(m_buf[i]);
          m_committed = 1; m_pos = 0;
        end
      end else model_err();
    end else begin
      m_gap++;
      if (m_gap >= TO) model_err();
    end
  endtask

  function automatic int exp_state();
    if (m_in_err)    return 5;
    if (m_committed) return 4;
    if (m_pos == 0)  return 0;
    return m_pos / 4 + 1;
  endfunction

  task automatic check_all();
    check("cap_state", 32'(cap_state_o), 32'(exp_state()));
    check("frame_done", 32'(frame_done_o), 32'(m_committed));
    check("frame_err", 32'(frame_err_o), 32'(m_sticky));
    for (int i = 0; i < 12; i++) check($sformatf("c_out[%0d]", i), 32'(c_o[i]), 32'(m_out[i]));
`ifdef DISPLAY_CAPTURE_SUM_EN
    check("sum", 32'(sum_o), 32'(m_sum));
`endif
  endtask

  // One clock cycle: drive, clock, advance model, compare 1 time unit after the edge
  task automatic step(input bit v, input logic [2:0] t, input logic [DW-1:0] d);
    valid_i = v; tag_i = t; data_i = d;
    @(posedge clk);
    #1;
    model_step(v, t, d);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'($urandom), DW'($urandom));
  endtask

  // Twelve words base..base+11 (or random data); optional gap after word gap_at;
  // word bad_at carries bad_tag instead of the correct group code.
  task automatic send_frame(input int base, input bit rnd, input int gap_at, input int gap_len,
                            input int bad_at, input logic [2:0] bad_tag);
    logic [2:0] t;
    for (int k = 0; k < 12; k++) begin
      t = (k == bad_at) ? bad_tag : 3'(k / 4 + 1);
      step(1'b1, t, rnd ? DW'($urandom) : DW'(base + k));
      if (k == gap_at) idle(gap_len);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0; valid_i = 1'b0; tag_i = '0; data_i = '0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    check_all();
    #2 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Back-to-back frame 1..12
    send_frame(1, 0, -1, 0, -1, 3'd0);
    idle(2);
    // Same frame with three idle cycles after word 6
    send_frame(1, 0, 5, 3, -1, 3'd0);
    idle(2);
    // Good frame, then a frame whose third word carries tag 2
    send_frame(1, 0, -1, 0, -1, 3'd0);
    idle(1);
    send_frame(40, 0, -1, 0, 2, 3'd2);
    idle(3);
    // Stall of TIMEOUT cycles after word 5, then frame 21..32
    for (int k = 0; k < 5; k++) step(1'b1, 3'(k / 4 + 1), DW'(50 + k));
    idle(TO);
    idle(2);
    send_frame(21, 0, -1, 0, -1, 3'd0);
    idle(1);
    // Gap of TIMEOUT-1 is tolerated
    apply_reset();
    send_frame(60, 0, 7, TO - 1, -1, 3'd0);
    idle(1);
    // Two back-to-back frames, second starts in the commit cycle
    send_frame(100, 0, -1, 0, -1, 3'd0);
    send_frame(200, 0, -1, 0, -1, 3'd0);
    idle(2);
    // Illegal tag code starting a frame
    step(1'b1, 3'd7, 8'd9);
    idle(2);

    // Asynchronous reset after word 7
    for (int k = 0; k < 7; k++) step(1'b1, 3'(k / 4 + 1), DW'(70 + k));
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    #2 reset = 1'b1;
    send_frame(80, 0, -1, 0, -1, 3'd0);
    idle(1);

    // Randomized frames: gaps, boundary gaps and (later) corrupted tags
    apply_reset();
    for (int f = 0; f < 40; f++) begin
      int r, bad;
      logic [2:0] t;
      bad = (f >= 10 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
      for (int k = 0; k < 12; k++) begin
        t = (k == bad) ? 3'($urandom) : 3'(k / 4 + 1);
        step(1'b1, t, DW'($urandom));
        r = int'($urandom_range(0, 39));
        if (r >= 30 && r < 37) idle(int'($urandom_range(1, 3)));
        else if (r == 37 || r == 38) idle(TO - 1);
        else if (r == 39) idle(TO);
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
